// File: rtl/ufm_seq_fetch_pkg.sv
// Shared types and constants for the UFM sequential fetcher.
//   state_e    : sequencer states (idle, fetching bytes, draining the FIFO)
//   UfmAddrW   : UFM byte address width
//   TimeoutMax : watchdog limit (used only when UFM_SEQ_TIMEOUT_EN is defined)
package ufm_seq_fetch_pkg;

  localparam int unsigned UfmAddrW   = 15;
  localparam int unsigned TimeoutMax = 255;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/ufm_seq_fetch_if.sv
// Bus bundle for ufm_seq_fetch: command channel, output byte stream, status
// and the ufm_reader side.
//   slave  : sequencer view (drives cmd_ready, out_*, status, ufm_addr/read_en)
//   master : environment view (drives cmd_*, out_ready, ufm_data/ufm_valid)
interface ufm_seq_fetch_if
  import ufm_seq_fetch_pkg::*;
#(
  parameter int unsigned LenW = 16
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [UfmAddrW-1:0] cmd_addr;
  logic [LenW-1:0]     cmd_len;

  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  logic                busy;
  logic                done;
  logic                err;

  logic [UfmAddrW-1:0] ufm_addr;
  logic                read_en;
  logic [7:0]          ufm_data;
  logic                ufm_valid;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, out_ready, ufm_data, ufm_valid,
    output cmd_ready, out_data, out_valid, out_last, busy, done, err, ufm_addr, read_en
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, out_ready, ufm_data, ufm_valid,
    input  cmd_ready, out_data, out_valid, out_last, busy, done, err, ufm_addr, read_en
  );

endinterface

// File: rtl/ufm_seq_fetch_byte_fifo.sv
// Synchronous first-word-fall-through FIFO holding {last, data} entries.
//   clk_i/rst_ni : clock, synchronous active-low reset
//   flush_i      : drop all contents
//   push_i/wdata_i, pop_i/rdata_o : write and head-of-queue read
//   full_o/empty_o : registered occupancy flags
// Pushes while full and pops while empty are ignored.
module ufm_seq_fetch_byte_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q && !flush_i;
  assign do_pop  = pop_i && !empty_q && !flush_i;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + (AddrW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AddrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == (AddrW+1)'(Depth));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/ufm_seq_fetch.sv
// UFM sequential fetcher: accepts {start address, byte count} commands, walks
// ufm_addr/read_en across consecutive UFM bytes and streams the returned bytes
// out through a small FIFO with a last marker on the final byte.
//   clk, rst : clock, synchronous active-low reset
//   bus      : ufm_seq_fetch_if.slave (command, output stream, status, ufm_reader side)
// Optional feature: define UFM_SEQ_TIMEOUT_EN for an 8-bit stall watchdog that aborts
// the command with err=1; otherwise FETCH waits indefinitely and err stays 0.
module ufm_seq_fetch
  import ufm_seq_fetch_pkg::*;
#(
  parameter int unsigned LenW      = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic            clk,
  input  logic            rst,
  ufm_seq_fetch_if.slave  bus
);

  state_e              state_q;
  logic [UfmAddrW-1:0] addr_q;
  logic [LenW-1:0]     rem_q;
  logic                done_q;
  logic                err_q;

  logic       cmd_ready, read_en, capture, pop, timeout;
  logic       fifo_full, fifo_empty;
  logic [8:0] fifo_head;

  // Masked during done so accept and done never share a cycle.
  assign cmd_ready = rst && (state_q == StIdle) && !done_q;
  assign read_en   = (state_q == StFetch) && !fifo_full;
  assign capture   = read_en && bus.ufm_valid;
  assign pop       = !fifo_empty && bus.out_ready;

`ifdef UFM_SEQ_TIMEOUT_EN
  logic [7:0] wdog_q;

  // Fires on the stall cycle that would bring the count to TimeoutMax.
  assign timeout = read_en && !bus.ufm_valid && (wdog_q == 8'(TimeoutMax - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if ((state_q != StFetch) || capture) begin
      wdog_q <= '0;
    end else if (read_en && !bus.ufm_valid) begin
      wdog_q <= wdog_q + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid && cmd_ready) begin
            addr_q <= bus.cmd_addr;
            rem_q  <= bus.cmd_len;
            err_q  <= 1'b0;
            if (bus.cmd_len == '0) done_q  <= 1'b1;
            else                   state_q <= StFetch;
          end
        end
        StFetch: begin
          if (timeout) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (capture) begin
            addr_q <= addr_q + UfmAddrW'(1);
            rem_q  <= rem_q - LenW'(1);
            if (rem_q == LenW'(1)) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && fifo_head[8]) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ufm_seq_fetch_byte_fifo #(
    .Depth (FifoDepth),
    .Width (9)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (timeout),
    .push_i  (capture),
    .wdata_i ({(rem_q == LenW'(1)), bus.ufm_data}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.cmd_ready = cmd_ready;
  assign bus.read_en   = read_en;
  assign bus.ufm_addr  = addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head[7:0];
  assign bus.out_last  = fifo_head[8];
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ufm_seq_fetch.sv
// Self-checking bench for ufm_seq_fetch. A UFM image in an array is served to
// the DUT; the expected stream for a command is the image bytes at start+i
// (15-bit wrap), with the last flag on byte len-1.
module tb_ufm_seq_fetch;

  localparam int unsigned LenW      = 16;
  localparam int unsigned FifoDepth = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ufm_seq_fetch_if #(.LenW(LenW)) bus ();

  ufm_seq_fetch #(
    .LenW      (LenW),
    .FifoDepth (FifoDepth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [32768];
  int vmode = 0;  // ufm_valid: 0 always, 1 random, 2 never
  int rmode = 0;  // out_ready: 0 always, 1 random, 2 never
  int cyc   = 0;

  logic [7:0]  rx_data [$];
  logic        rx_last [$];
  logic [14:0] cap_addr [$];
  int done_cnt, done_cyc, first_vld_cyc, first_cap_cyc, last_pop_cyc;
  int vld_seen, ren_seen, coin_cnt;
  logic        prev_stall = 1'b0;
  logic [14:0] prev_addr  = '0;

  function automatic logic [7:0] exp_byte(input logic [14:0] a, input int i);
    logic [14:0] x;
    x = a + 15'(i);
    return mem[x];
  endfunction

  // Drive UFM/consumer side on the falling edge, then log what the next rising edge does.
  always @(negedge clk) begin
    cyc++;
    bus.ufm_valid = (vmode == 0) || (vmode == 1 && $urandom_range(1, 0) == 1);
    bus.out_ready = (rmode == 0) || (rmode == 1 && $urandom_range(1, 0) == 1);
    bus.ufm_data  = mem[bus.ufm_addr];
    #1;
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    if (bus.done && bus.cmd_ready) coin_cnt++;
    if (bus.out_valid) begin
      vld_seen++;
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
    end
    if (bus.read_en) ren_seen++;
    if (prev_stall && bus.read_en) begin
      checks++;
      if (bus.ufm_addr !== prev_addr) begin
        errors++;
        $display("FAIL addr_stable: got %h want %h", bus.ufm_addr, prev_addr);
      end
    end
    prev_stall = bus.read_en && !bus.ufm_valid;
    prev_addr  = bus.ufm_addr;
    if (bus.read_en && bus.ufm_valid) begin
      cap_addr.push_back(bus.ufm_addr);
      if (first_cap_cyc < 0) first_cap_cyc = cyc;
    end
    if (bus.out_valid && bus.out_ready) begin
      rx_data.push_back(bus.out_data);
      rx_last.push_back(bus.out_last);
      last_pop_cyc = cyc;
    end
  end

  task automatic clear_obs();
    rx_data.delete(); rx_last.delete(); cap_addr.delete();
    done_cnt = 0; done_cyc = -1; first_vld_cyc = -1; first_cap_cyc = -1;
    last_pop_cyc = -1; vld_seen = 0; ren_seen = 0;
  endtask

  task automatic issue(input logic [14:0] a, input logic [15:0] l, output int acc);
    int guard;
    guard = 0;
    @(negedge clk); #2;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk); #2;
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready got 0 want 1 within 50 cycles");
    end
    acc = cyc;
    @(negedge clk); #2;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(negedge clk); #2;
      n++;
    end
    if (done_cnt == 0) begin
      checks++; errors++;
      $display("FAIL done_wait: no done within %0d cycles", bound);
    end
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.out_valid, bus.read_en, bus.done, bus.err} !== 6'b0
        || bus.ufm_addr !== 15'h0) begin
      errors++;
      $display("FAIL reset_state: rdy/busy/ov/ren/done/err=%b addr=%h want 0",
               {bus.cmd_ready, bus.busy, bus.out_valid, bus.read_en, bus.done, bus.err},
               bus.ufm_addr);
    end
    rst = 1'b1;
    @(negedge clk); #2;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_basic();
    int acc;
    vmode = 0; rmode = 0;
    clear_obs();
    issue(15'h0010, 16'd4, acc);
    wait_done(100);
    checks++;
    if (rx_data.size() != 4) begin
      errors++;
      $display("FAIL basic_count: got %0d want 4", rx_data.size());
    end
    for (int i = 0; i < rx_data.size() && i < 4; i++) begin
      checks++;
      if (rx_data[i] !== exp_byte(15'h0010, i) || rx_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h/%b want %h/%b", i, rx_data[i], rx_last[i],
                 exp_byte(15'h0010, i), (i == 3));
      end
    end
    checks++;
    if (first_cap_cyc != acc + 1 || first_vld_cyc != first_cap_cyc + 1) begin
      errors++;
      $display("FAIL basic_latency: cap=%0d vld=%0d want %0d %0d", first_cap_cyc,
               first_vld_cyc, acc + 1, acc + 2);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_pop_cyc + 1) begin
      errors++;
      $display("FAIL basic_done: count=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc,
               last_pop_cyc + 1);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy=%b err=%b want 0 0", bus.busy, bus.err);
    end
  endtask

  task automatic test_zero_len();
    int acc;
    vmode = 0; rmode = 0;
    clear_obs();
    issue(15'h0055, 16'd0, acc);
    wait_done(10);
    checks++;
    if (done_cnt != 1 || done_cyc != acc + 1) begin
      errors++;
      $display("FAIL zero_done: count=%0d cyc=%0d want 1 %0d", done_cnt, done_cyc, acc + 1);
    end
    checks++;
    if (vld_seen != 0 || ren_seen != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_quiet: out_valid %0d read_en %0d busy %b want 0 0 0",
               vld_seen, ren_seen, bus.busy);
    end
  endtask

  task automatic test_wrap();
    int acc;
    vmode = 0; rmode = 0;
    clear_obs();
    issue(15'h7FFE, 16'd3, acc);
    wait_done(100);
    checks++;
    if (cap_addr.size() != 3) begin
      errors++;
      $display("FAIL wrap_caps: got %0d want 3", cap_addr.size());
    end
    for (int i = 0; i < cap_addr.size() && i < 3; i++) begin
      checks++;
      if (cap_addr[i] !== 15'(15'h7FFE + 15'(i))) begin
        errors++;
        $display("FAIL wrap_addr%0d: got %h want %h", i, cap_addr[i], 15'(15'h7FFE + 15'(i)));
      end
    end
    checks++;
    if (rx_data.size() != 3) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 3", rx_data.size());
    end
    for (int i = 0; i < rx_data.size() && i < 3; i++) begin
      checks++;
      if (rx_data[i] !== exp_byte(15'h7FFE, i) || rx_last[i] !== (i == 2)) begin
        errors++;
        $display("FAIL wrap_byte%0d: got %h/%b want %h/%b", i, rx_data[i], rx_last[i],
                 exp_byte(15'h7FFE, i), (i == 2));
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    vmode = 0; rmode = 2;
    clear_obs();
    issue(15'h0123, 16'd8, acc);
    repeat (15) @(negedge clk);
    #2;
    checks++;
    if (cap_addr.size() != FifoDepth || bus.read_en !== 1'b0 || rx_data.size() != 0
        || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: caps=%0d read_en=%b pops=%0d ov=%b want %0d 0 0 1",
               cap_addr.size(), bus.read_en, rx_data.size(), bus.out_valid, FifoDepth);
    end
    rmode = 0;
    wait_done(100);
    checks++;
    if (rx_data.size() != 8) begin
      errors++;
      $display("FAIL bp_count: got %0d want 8", rx_data.size());
    end
    for (int i = 0; i < rx_data.size() && i < 8; i++) begin
      checks++;
      if (rx_data[i] !== exp_byte(15'h0123, i) || rx_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL bp_byte%0d: got %h/%b want %h/%b", i, rx_data[i], rx_last[i],
                 exp_byte(15'h0123, i), (i == 7));
      end
    end
  endtask

  task automatic test_random();
    int acc;
    logic [14:0] a;
    int l;
    vmode = 1; rmode = 1;
    for (int k = 0; k < 6; k++) begin
      a = 15'($urandom);
      l = (k == 0) ? 16 : int'($urandom_range(24, 1));
      clear_obs();
      issue(a, 16'(l), acc);
      wait_done(l * 20 + 50);
      checks++;
      if (rx_data.size() != l || done_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d_count: bytes %0d done %0d want %0d 1", k, rx_data.size(),
                 done_cnt, l);
      end
      for (int i = 0; i < rx_data.size() && i < l; i++) begin
        checks++;
        if (rx_data[i] !== exp_byte(a, i) || rx_last[i] !== (i == l - 1)) begin
          errors++;
          $display("FAIL rand%0d_byte%0d: got %h/%b want %h/%b", k, i, rx_data[i],
                   rx_last[i], exp_byte(a, i), (i == l - 1));
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int acc, n;
    vmode = 1; rmode = 1;
    clear_obs();
    issue(15'h0400, 16'd6, acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 15'h0777;
    bus.cmd_len   = 16'd3;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(negedge clk); #2;
      if (bus.busy) begin
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready: cmd_ready got %b want 0", bus.cmd_ready);
        end
      end
      n++;
    end
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (done_cnt != 1 || bus.busy !== 1'b0 || rx_data.size() != 6 || coin_cnt != 0) begin
      errors++;
      $display("FAIL busy_result: done %0d busy %b bytes %0d coincide %0d want 1 0 6 0",
               done_cnt, bus.busy, rx_data.size(), coin_cnt);
    end
    for (int i = 0; i < rx_data.size() && i < 6; i++) begin
      checks++;
      if (rx_data[i] !== exp_byte(15'h0400, i) || rx_last[i] !== (i == 5)) begin
        errors++;
        $display("FAIL busy_byte%0d: got %h/%b want %h/%b", i, rx_data[i], rx_last[i],
                 exp_byte(15'h0400, i), (i == 5));
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    vmode = 0; rmode = 2;
    clear_obs();
    issue(15'h0200, 16'd16, acc);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk); #2;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.out_valid, bus.out_last, bus.read_en, bus.done,
         bus.err} !== 7'b0 || bus.ufm_addr !== 15'h0) begin
      errors++;
      $display("FAIL mid_reset: rdy/busy/ov/ol/ren/done/err=%b addr=%h want 0",
               {bus.cmd_ready, bus.busy, bus.out_valid, bus.out_last, bus.read_en,
                bus.done, bus.err}, bus.ufm_addr);
    end
    rst = 1'b1;
    rmode = 0;
    clear_obs();
    issue(15'h0300, 16'd2, acc);
    wait_done(50);
    checks++;
    if (rx_data.size() != 2 || rx_data[0] !== exp_byte(15'h0300, 0)
        || rx_data[1] !== exp_byte(15'h0300, 1) || rx_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: bytes %0d first %h want 2 %h", rx_data.size(),
               (rx_data.size() > 0) ? rx_data[0] : 8'hxx, exp_byte(15'h0300, 0));
    end
  endtask

`ifdef UFM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    vmode = 2; rmode = 0;
    clear_obs();
    issue(15'h0040, 16'd5, acc);
    wait_done(400);
    checks++;
    if (done_cyc != acc + 256 || bus.err !== 1'b1 || vld_seen != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: done_at %0d err %b out_valid %0d busy %b want %0d 1 0 0",
               done_cyc - acc, bus.err, vld_seen, bus.busy, 256);
    end
    vmode = 0;
    clear_obs();
    issue(15'h0041, 16'd1, acc);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err got %b want 0", bus.err);
    end
    wait_done(50);
  endtask
`endif

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    bus.ufm_valid = 1'b0;
    bus.ufm_data  = '0;
    coin_cnt = 0;
    clear_obs();
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_backpressure();
    test_random();
    test_busy_ignore();
    test_reset_mid();
`ifdef UFM_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
